// File: rtl/alu_ctrl_fsm_if.sv
// alu_ctrl_fsm_if
// Bundles every non-clock/reset signal of the control sequencer.
//   Start, Instr, alu_zero, mem_ack       : environment -> sequencer
//   alu_op, alu_b_sel, reg_we, wb_sel     : ALU / register-file controls
//   mem_req, mem_we                       : data-memory request
//   pc_clr, pc_inc, pc_branch             : PC controls
//   ir_q, done, err, instr_cnt            : status
//   state_dbg                             : current FSM state for observation
// Modports: master = the sequencer, slave = the surrounding core / memory.
//
// Memory handshake: mem_req rises when the sequencer enters MEM and stays high
// (with mem_we stable) until the cycle in which mem_ack is sampled high; that
// cycle completes the transfer. mem_ack is a single-cycle pulse and is ignored
// whenever mem_req is low.
interface alu_ctrl_fsm_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic [8:0]       Instr;
  logic             alu_zero;
  logic             mem_ack;
  logic [2:0]       alu_op;
  logic             alu_b_sel;
  logic             reg_we;
  logic             wb_sel;
  logic             mem_req;
  logic             mem_we;
  logic             pc_clr;
  logic             pc_inc;
  logic             pc_branch;
  logic [8:0]       ir_q;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] instr_cnt;
  logic [2:0]       state_dbg;

  modport master (
    input  Start, Instr, alu_zero, mem_ack,
    output alu_op, alu_b_sel, reg_we, wb_sel, mem_req, mem_we,
           pc_clr, pc_inc, pc_branch, ir_q, done, err, instr_cnt, state_dbg
  );

  modport slave (
    output Start, Instr, alu_zero, mem_ack,
    input  alu_op, alu_b_sel, reg_we, wb_sel, mem_req, mem_we,
           pc_clr, pc_inc, pc_branch, ir_q, done, err, instr_cnt, state_dbg
  );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm
// Multi-cycle control sequencer for the 8-bit core: fetches a 9-bit
// instruction, decodes opcode Instr[8:6] and sequences the ALU, register file,
// PC and data memory. Includes a bounded memory wait that traps to ERR and a
// saturating retired-instruction counter.
// Ports:
//   Clk      rising-edge clock
//   Reset_n  asynchronous active-low reset
//   bus      alu_ctrl_fsm_if.master (see interface header for signal list)
module alu_ctrl_fsm #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic           Clk,
  input  logic           Reset_n,
  alu_ctrl_fsm_if.master bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam logic [2:0] OP_STP  = 3'b000;
  localparam logic [2:0] OP_SHF  = 3'b001;
  localparam logic [2:0] OP_BNEG = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_ST   = 3'b110;
  localparam logic [2:0] OP_LD   = 3'b111;

  // Last MEM cycle index allowed without an ack.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state, state_nx;
  logic [8:0]       ir_q;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op;
  logic             restart;
  logic             retire;

  logic [2:0] alu_op;
  logic       alu_b_sel, reg_we, wb_sel, mem_req, mem_we;
  logic       pc_clr, pc_inc, pc_branch, done, err;

  assign op      = ir_q[8:6];
  assign restart = ((state == IDLE) || (state == HALT) || (state == ERR)) && bus.Start;

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Instruction register, memory wait counter, retired counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ir_q     <= '0;
      wait_cnt <= '0;
      cnt      <= '0;
    end else begin
      if (state == FETCH) ir_q <= bus.Instr;

      if (state == EXEC)
        wait_cnt <= '0;
      else if (state == MEM && !bus.mem_ack && wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + 8'd1;

      if (restart)
        cnt <= '0;
      else if (retire && cnt != '1)
        cnt <= cnt + 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, HALT, ERR: if (bus.Start) state_nx = FETCH;
      FETCH:           state_nx = DECODE;
      DECODE:          state_nx = (op == OP_STP) ? HALT : EXEC;
      EXEC:            state_nx = (op == OP_LD || op == OP_ST) ? MEM : FETCH;
      MEM: begin
        // An ack in the timeout cycle still completes the access.
        if (bus.mem_ack)              state_nx = (op == OP_LD) ? WB : FETCH;
        else if (wait_cnt == WAIT_LAST) state_nx = ERR;
      end
      WB:              state_nx = FETCH;
      default:         state_nx = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    alu_op    = 3'b000;
    alu_b_sel = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    pc_clr    = 1'b0;
    pc_inc    = 1'b0;
    pc_branch = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: pc_clr = bus.Start;
      HALT: begin
        done   = 1'b1;
        pc_clr = bus.Start;
      end
      ERR: begin
        err    = 1'b1;
        pc_clr = bus.Start;
      end
      DECODE: alu_op = op;
      EXEC: begin
        alu_op    = op;
        alu_b_sel = (op == OP_ADDI);
        case (op)
          OP_ADD, OP_ADDI, OP_NOR, OP_SHF: begin
            reg_we = 1'b1;
            pc_inc = 1'b1;
            retire = 1'b1;
          end
          OP_BNEG: begin
            // alu_zero flags a negative operand: take the branch.
            pc_branch = bus.alu_zero;
            pc_inc    = !bus.alu_zero;
            retire    = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        alu_op  = op;
        mem_req = 1'b1;
        mem_we  = (op == OP_ST);
        if (bus.mem_ack && op == OP_ST) begin
          pc_inc = 1'b1;
          retire = 1'b1;
        end
      end
      WB: begin
        reg_we = 1'b1;
        wb_sel = 1'b1;
        pc_inc = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.alu_op    = alu_op;
  assign bus.alu_b_sel = alu_b_sel;
  assign bus.reg_we    = reg_we;
  assign bus.wb_sel    = wb_sel;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.pc_clr    = pc_clr;
  assign bus.pc_inc    = pc_inc;
  assign bus.pc_branch = pc_branch;
  assign bus.done      = done;
  assign bus.err       = err;
  assign bus.ir_q      = ir_q;
  assign bus.instr_cnt = cnt;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm
// Builds a per-cycle stimulus/expectation trace from an instruction-level
// model (what each instruction class must show in each of its cycles), then
// replays it against alu_ctrl_fsm and compares outputs every cycle.
module tb_alu_ctrl_fsm;
  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int W           = 13 + 9 + CNT_W;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;
  localparam int M_ERR  = 3;

  localparam logic [2:0] STP  = 3'b000;
  localparam logic [2:0] SHF  = 3'b001;
  localparam logic [2:0] BNEG = 3'b010;
  localparam logic [2:0] NOR  = 3'b011;
  localparam logic [2:0] ADD  = 3'b100;
  localparam logic [2:0] ADDI = 3'b101;
  localparam logic [2:0] ST   = 3'b110;
  localparam logic [2:0] LD   = 3'b111;

  // clock / reset
  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  alu_ctrl_fsm_if #(.CNT_W(CNT_W)) bus();

  alu_ctrl_fsm #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  typedef struct packed {
    logic       start;
    logic [8:0] instr;
    logic       zero;
    logic       ack;
  } stim_t;

  // scoreboard
  stim_t          stim_q[$];
  logic [W-1:0]   exp_q[$];
  string          tag_q[$];
  int             total = 0;
  int             bad   = 0;

  // reference model state
  logic [CNT_W-1:0] m_cnt;
  logic [8:0]       m_ir;
  int               m_mode;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [8:0] r9();
    return 9'($urandom);
  endfunction

  function automatic logic [12:0] ov(input logic [2:0] a, input logic bs, input logic rw,
                                     input logic ws, input logic rq, input logic we,
                                     input logic clr, input logic inc, input logic br,
                                     input logic dn, input logic er);
    return {a, bs, rw, ws, rq, we, clr, inc, br, dn, er};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.alu_op, bus.alu_b_sel, bus.reg_we, bus.wb_sel, bus.mem_req, bus.mem_we,
            bus.pc_clr, bus.pc_inc, bus.pc_branch, bus.done, bus.err, bus.ir_q, bus.instr_cnt};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    assert (act === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic retire();
    if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
  endtask

  task automatic push(input logic start, input logic [8:0] instr, input logic zero,
                      input logic ack, input logic [12:0] o, input string tag);
    stim_t s;
    s = '{start: start, instr: instr, zero: zero, ack: ack};
    stim_q.push_back(s);
    exp_q.push_back({o, m_ir, m_cnt});
    tag_q.push_back(tag);
  endtask

  // Idle/halt/error cycles with Start low
  task automatic add_wait(input int n);
    for (int i = 0; i < n; i++)
      push(1'b0, r9(), rb(), rb(),
           ov(3'b0, 0, 0, 0, 0, 0, 0, 0, 0, m_mode == M_HALT, m_mode == M_ERR), "wait");
  endtask

  task automatic add_start();
    push(1'b1, r9(), rb(), rb(),
         ov(3'b0, 0, 0, 0, 0, 0, 1, 0, 0, m_mode == M_HALT, m_mode == M_ERR), "start");
    m_cnt  = '0;
    m_mode = M_RUN;
  endtask

  // One instruction from FETCH. delay = no-ack MEM cycles before the ack
  // (>= MEM_TIMEOUT means no ack at all); delay < 0 stops after EXEC.
  // zsel: 0/1 force alu_zero in EXEC, 2 random.
  task automatic add_instr(input logic [8:0] ins, input int delay, input int zsel);
    logic [2:0] op;
    logic       z;
    logic       a;
    op = ins[8:6];
    push(rb(), ins, rb(), rb(), 13'b0, "fetch");
    m_ir = ins;
    push(rb(), r9(), rb(), rb(), ov(op, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "decode");
    if (op == STP) begin
      m_mode = M_HALT;
      return;
    end
    if (op == BNEG) begin
      z = (zsel == 2) ? rb() : 1'(zsel);
      push(rb(), r9(), z, rb(), ov(op, 0, 0, 0, 0, 0, 0, !z, z, 0, 0), "exec_bneg");
      retire();
      return;
    end
    if (op != LD && op != ST) begin
      push(rb(), r9(), rb(), rb(), ov(op, op == ADDI, 1, 0, 0, 0, 0, 1, 0, 0, 0), "exec_alu");
      retire();
      return;
    end
    push(rb(), r9(), rb(), rb(), ov(op, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "exec_mem");
    if (delay < 0) return;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      a = (i == delay);
      push(rb(), r9(), rb(), a, ov(op, 0, 0, 0, 1, op == ST, 0, a && op == ST, 0, 0, 0), "mem");
      if (a) break;
    end
    if (delay >= MEM_TIMEOUT) begin
      m_mode = M_ERR;
      return;
    end
    if (op == ST) begin
      retire();
    end else begin
      push(rb(), r9(), rb(), rb(), ov(3'b0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0), "wb");
      retire();
    end
  endtask

  // driver: called at a falling edge, replays the queued trace
  task automatic run_q();
    stim_t        s;
    logic [W-1:0] e;
    string        t;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      bus.Start    = s.start;
      bus.Instr    = s.instr;
      bus.alu_zero = s.zero;
      bus.mem_ack  = s.ack;
      #1;
      check(t, observed(), e);
      @(negedge Clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ops[7];
    logic [2:0] op;
    int         d;
    ops = '{SHF, NOR, BNEG, ST, ADD, ADDI, LD};
    bus.Start = 1'b0; bus.Instr = '0; bus.alu_zero = 1'b0; bus.mem_ack = 1'b0;
    m_cnt = '0; m_ir = '0; m_mode = M_IDLE;

    // reset state
    @(negedge Clk);
    #1;
    check("reset", observed(), '0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // add then stp, halt, restart
    add_wait(2);
    add_start();
    add_instr(9'b100_000001, 0, 2);
    add_instr(9'b000_000000, 0, 2);
    add_wait(3);
    add_start();
    // bneg taken / not taken
    add_instr({BNEG, 6'($urandom)}, 0, 1);
    add_instr({BNEG, 6'($urandom)}, 0, 0);
    // ld with 2-cycle ack delay, st immediate, st with ack in the timeout cycle
    add_instr({LD, 6'($urandom)}, 2, 2);
    add_instr({ST, 6'($urandom)}, 0, 2);
    add_instr({ST, 6'($urandom)}, MEM_TIMEOUT - 1, 2);
    add_instr({LD, 6'($urandom)}, 0, 2);
    // st timeout -> sticky err -> restart
    add_instr({ST, 6'($urandom)}, MEM_TIMEOUT, 2);
    add_wait(3);
    add_start();
    // counter saturation
    for (int i = 0; i < 17; i++) add_instr({ADD, 6'($urandom)}, 0, 2);
    run_q();
    check("sat_cnt", W'(bus.instr_cnt), W'(4'd15));

    // random instruction stream
    for (int i = 0; i < 80; i++) begin
      op = (($urandom_range(0, 11)) == 0) ? STP : ops[$urandom_range(0, 6)];
      d  = $urandom_range(0, MEM_TIMEOUT);
      add_instr({op, 6'($urandom)}, d, 2);
      if (m_mode != M_RUN) begin
        add_wait($urandom_range(1, 3));
        add_start();
      end
    end
    run_q();

    // asynchronous reset while a load waits in MEM
    add_instr({LD, 6'($urandom)}, -1, 2);
    run_q();
    bus.Start = 1'b0; bus.mem_ack = 1'b0; bus.Instr = r9();
    #1;
    check("mem_pre_rst", observed(), {ov(LD, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), m_ir, m_cnt});
    Reset_n = 1'b0;
    #1;
    check("async_rst", observed(), '0);
    @(negedge Clk);
    check("rst_hold", observed(), '0);
    Reset_n = 1'b1;
    m_cnt = '0; m_ir = '0; m_mode = M_IDLE;
    add_wait(1);
    add_start();
    add_instr({ADDI, 6'($urandom)}, 0, 2);
    add_instr({LD, 6'($urandom)}, 1, 2);
    run_q();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_ctrl_fsm.md
Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the 8-bit core.
- Fetches a 9-bit instruction, decodes the 3-bit opcode, and drives the ALU opcode, operand select, register-file write, PC update and memory handshake.
- Sits between the instruction ROM/PC, the register file, the shared 8-bit ALU (OP[2:0] in, zero flag out) and data memory.
- Adds a bounded memory wait with error trap and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- MEM_TIMEOUT, 8, max MEM-state cycles without mem_ack before trapping to ERR (legal range 1..255).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  launch/restart request, level-sampled.
- Instr  in  9  instruction from ROM at current PC; opcode = Instr[8:6].
- alu_zero  in  1  ALU zero flag.
- mem_ack  in  1  data memory completion, one-cycle pulse.
- alu_op  out  3  opcode to ALU.
- alu_b_sel  out  1  ALU B operand: 0 = register, 1 = IR immediate.
- reg_we  out  1  register file write enable.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  memory write qualifier (valid with mem_req).
- pc_clr  out  1  PC reset to 0.
- pc_inc  out  1  PC <= PC+1.
- pc_branch  out  1  PC <= branch target.
- ir_q  out  9  registered instruction.
- done  out  1  halted via stp.
- err  out  1  memory timeout trap.
- instr_cnt  out  CNT_W  retired instructions.

Behaviour:
- Opcodes: 000 stp, 001 shf, 011 nor, 010 bneg, 110 st, 100 add, 101 addi, 111 ld.
- Reset (async, Reset_n=0): state=IDLE, ir_q=0, wait counter=0, instr_cnt=0. Every output is 0.
- Output timing:
  - All outputs are decoded combinationally from state and ir_q, except pc_branch (also uses alu_zero) and the MEM-exit strobes (also use mem_ack).
  - Any output not listed for a state is 0.
- States and transitions:
  - IDLE: Start=1 -> pc_clr=1, instr_cnt cleared, go FETCH.
  - FETCH: ir_q <= Instr at the clock edge -> DECODE.
  - DECODE: alu_op=ir_q[8:6]. Opcode 000 -> HALT; else -> EXEC.
  - EXEC: alu_op=ir_q[8:6]; alu_b_sel=1 only for addi.
    - add/addi/nor/shf: reg_we=1, wb_sel=0, pc_inc=1, retire, -> FETCH.
    - bneg: if alu_zero=1 (operand negative) pc_branch=1, else pc_inc=1; retire; -> FETCH. pc_branch and pc_inc are never both 1.
    - ld/st: -> MEM, wait counter cleared.
  - MEM: mem_req=1, mem_we=(opcode==110), alu_op held at ir_q[8:6].
    - mem_ack=1 and st: pc_inc=1, retire, -> FETCH.
    - mem_ack=1 and ld: -> WB.
    - No ack: wait counter++. When the counter reaches MEM_TIMEOUT-1 without ack -> ERR; mem_req drops on the next cycle.
    - Ack in the same cycle as the timeout wins (completes normally).
  - WB: reg_we=1, wb_sel=1, pc_inc=1, retire, -> FETCH.
  - HALT: done=1. Start=1 -> pc_clr=1, instr_cnt cleared, -> FETCH (done drops).
  - ERR: err=1, sticky. Start=1 -> same restart as HALT.
- Latencies (FETCH through return to FETCH):
  - ALU ops and bneg: 3 cycles.
  - st: 4+k cycles.
  - ld: 5+k cycles.
  - k = cycles of mem_ack delay after the first MEM cycle.
- instr_cnt:
  - Increments by 1 on each retire; stp does not count.
  - Saturates at 2^CNT_W-1 (no wrap).
- Ignored inputs:
  - Start is ignored outside IDLE/HALT/ERR.
  - mem_ack is ignored outside MEM.
- Reset mid-operation: immediate return to IDLE; an in-flight mem_req drops asynchronously.
- Illegal/unused state encodings recover to IDLE on the next clock.

Test Plan:
- Reset, Start=1 one cycle, Instr=100_000001 then 000_000000 -> pc_clr in IDLE cycle; reg_we=1 and alu_op=100 in cycle 3 after FETCH; done=1; instr_cnt=1.
- bneg with alu_zero=1, then bneg with alu_zero=0 -> pc_branch=1/pc_inc=0, then pc_branch=0/pc_inc=1; each in EXEC; instr_cnt=2.
- ld with mem_ack 2 cycles after MEM entry -> mem_req high 3 cycles, mem_we=0; WB shows reg_we=1, wb_sel=1; 7 cycles FETCH-to-FETCH.
- st with MEM_TIMEOUT=4 and no ack -> mem_req high exactly 4 cycles, mem_we=1, then err=1 sticky; Start=1 -> pc_clr, err=0, FETCH.
- Assert Reset_n=0 asynchronously during MEM -> all outputs 0 before the next clock edge; state IDLE; instr_cnt=0.
- Force instr_cnt to 2^CNT_W-1 (CNT_W=4: 15 add instructions) then one more add -> instr_cnt stays 15.
